iter_down_counter: RTL and testbench
====================================

ITER_DOWN_COUNTER -- requirements
Module: iter_down_counter

Interface
REQ-001 SHALL have parameter N, default 4, meaning counter width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to load and begin counting.
REQ-005 SHALL have port load_val  input  N  iteration count captured on accepted start.
REQ-006 SHALL have port hold  input  1  pauses decrementing while high.
REQ-007 SHALL have port count  output  N  current registered count.
REQ-008 SHALL have port busy  output  1  high in RUN state.
REQ-009 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-010 SHALL have port zero  output  1  combinational, high when count == 0.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; one-hot or binary encoding from shared package.
REQ-012 IDLE: start high and load_val != 0 -> count <= load_val, next RUN; start high and load_val == 0 -> count <= 0, next DONE.
REQ-013 IDLE without start SHALL hold count unchanged.
REQ-014 RUN: hold low -> count <= count - 1 via dec_by1; hold high -> count unchanged.
REQ-015 RUN: decrement producing 0 (count == 1, hold low) -> next DONE in same edge.
REQ-016 DONE: done = 1 for exactly one cycle, then unconditional next IDLE; count stays 0.
REQ-017 start SHALL be ignored in RUN and DONE (no reload, no restart).
REQ-018 hold SHALL be ignored in IDLE and DONE.
REQ-019 Count SHALL never wrap below 0; dec_by1 borrow out asserting in RUN is an error and SHALL not occur.
REQ-020 Latency: start with load_val = K (K >= 1), no hold -> done high exactly K+1 cycles after the start edge; busy high K cycles.
REQ-021 busy, done SHALL be registered (decoded from state register only).

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, count 0, busy 0, done 0 (zero therefore 1), regardless of clk.
REQ-023 Reset mid-RUN SHALL abandon the operation with no done pulse; first start after release behaves per REQ-012.

Configuration
REQ-024 Macro ITER_CNT_ABORT_EN SHALL, when defined, add port abort  input  1.
REQ-025 With ITER_CNT_ABORT_EN: abort high in RUN -> next IDLE, count <= 0, no done pulse; abort has priority over hold; ignored in IDLE/DONE.
REQ-026 Without ITER_CNT_ABORT_EN: no abort port; RUN exits only via REQ-015 or reset.

Structure
REQ-027 Shared package mult_pkg SHALL hold the state typedef/encodings and default width constant.
REQ-028 Sub-module dec_by1 (parameter N; outputs s = a - 1, bOut = 1 when a == 0; input a) SHALL be a combinational borrow look-ahead decrementer: s[0] = ~a[0], borrow into bit i = NOR of a[i-1:0], s[i] = a[i] XOR borrow, bOut = NOR of all a.
REQ-029 iter_down_counter SHALL instantiate exactly one dec_by1 and contain no other arithmetic operator on count.

Verification
REQ-030 N=4, start with load_val=5, hold=0 -> count 5,4,3,2,1,0; busy high 5 cycles; done pulse at cycle 6; IDLE at cycle 7.
REQ-031 load_val=0 with start -> busy never high; done pulse next cycle; count 0.
REQ-032 load_val=15, hold high cycles 3-5 -> count frozen at 13 for 3 cycles; done at cycle 19.
REQ-033 start re-asserted with load_val=9 during RUN of load_val=3 -> ignored; done after 4 cycles; count never 9.
REQ-034 rst_n low asynchronously at count=2 -> count 0, busy 0 before next edge; no done pulse.
REQ-035 dec_by1 exhaustive N=4: all 16 a values -> s = a-1 mod 16, bOut only for a=0; with ITER_CNT_ABORT_EN, abort at count=6 -> IDLE, no done.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mult_pkg
//  Description : State encoding and default width shared by the iteration
//                down-counter and its decrementer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Default counter width in bits
  localparam int unsigned C_DEFAULT_N = 4;

  // Binary-encoded controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/dec_by1.sv
`default_nettype none
// ============================================================================
//  Module      : dec_by1
//  Description : Combinational borrow look-ahead decrement-by-one.
//                The borrow into each bit is the NOR of all lower bits, so
//                no ripple chain exists. bOut flags a == 0 (result wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module dec_by1 #(
  parameter int unsigned N = mult_pkg::C_DEFAULT_N
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] s,
  output logic         bOut
);

  logic [N-1:0] w_brw;

  // Bit 0 always receives a borrow
  assign w_brw[0] = 1'b1;

  // Look-ahead borrow: bit i borrows only when every lower bit is zero
  for (genvar gi = 1; gi < N; gi++) begin : g_brw
    assign w_brw[gi] = ~|a[gi-1:0];
  end

  // Each result bit toggles when it receives a borrow
  for (genvar gi = 0; gi < N; gi++) begin : g_sum
    assign s[gi] = a[gi] ^ w_brw[gi];
  end

  assign bOut = ~|a;

endmodule : dec_by1
`default_nettype wire

// File: rtl/iter_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_down_counter
//  Description : Loadable iteration down-counter with hold. A start in IDLE
//                loads load_val and counts down to zero, then pulses done
//                for one cycle. A zero load goes straight to DONE.
//                Optional macro ITER_CNT_ABORT_EN adds an abort input that
//                cancels a running count without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_down_counter
  import mult_pkg::*;
#(
  parameter int unsigned N = C_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         hold,
`ifdef ITER_CNT_ABORT_EN
  input  logic         abort,
`endif
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  state_t       r_state;
  state_t       w_nstate;
  logic [N-1:0] r_count;
  logic [N-1:0] w_ncount;
  logic [N-1:0] w_dec;
  logic         w_cnt_zero;
  logic         w_abort;

`ifdef ITER_CNT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // The only arithmetic on the count; bOut doubles as the zero flag
  dec_by1 #(
    .N (N)
  ) u_dec (
    .a    (r_count),
    .s    (w_dec),
    .bOut (w_cnt_zero)
  );

  // State and count registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nstate;
      r_count <= w_ncount;
    end
  end

  // Next-state and next-count logic
  always_comb begin
    w_nstate = r_state;
    w_ncount = r_count;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (|load_val) begin
            w_ncount = load_val;
            w_nstate = ST_RUN;
          end else begin
            w_ncount = '0;
            w_nstate = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_ncount = '0;
          w_nstate = ST_IDLE;
        end else if (!hold) begin
          // RUN is only entered with a non-zero count and left on reaching
          // zero, so the decrement never borrows out here
          w_ncount = w_dec;
          if (~|w_dec) begin
            w_nstate = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_ncount = '0;
        w_nstate = ST_IDLE;
      end
      default: begin
        w_ncount = '0;
        w_nstate = ST_IDLE;
      end
    endcase
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign zero  = w_cnt_zero;

endmodule : iter_down_counter
`default_nettype wire

// File: tb/tb_iter_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_down_counter
//  Description : Directed self-checking bench for iter_down_counter (N=4)
//                and a standalone dec_by1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_down_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] load_val;
  logic       hold;
`ifdef ITER_CNT_ABORT_EN
  logic       abort;
`endif
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       zero;

  logic [3:0] t_a;
  logic [3:0] t_s;
  logic       t_b;

  int n_cmp;
  int n_bad;

  iter_down_counter #(
    .N (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .hold     (hold),
`ifdef ITER_CNT_ABORT_EN
    .abort    (abort),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  dec_by1 #(
    .N (4)
  ) u_dec_chk (
    .a    (t_a),
    .s    (t_s),
    .bOut (t_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (count !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    n_cmp++;
    if ({busy, done, zero} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_flags: busy/done/zero got %b want 001", {busy, done, zero});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL idle_after_reset: count/busy/done got %0d/%b/%b want 0/0/0", count, busy, done);
    end
  endtask

  // load_val=5: counts 5..1 busy, then 0 with done, then idle
  task automatic test_basic();
    logic [3:0] e_cnt;
    logic       e_busy;
    logic       e_done;
    start    = 1'b1;
    load_val = 4'd5;
    tick();
    start    = 1'b0;
    load_val = 4'd0;
    for (int c = 1; c <= 7; c++) begin
      e_cnt  = (c <= 6) ? 4'(6 - c) : 4'd0;
      e_busy = (c <= 5);
      e_done = (c == 6);
      n_cmp++;
      if ({count, busy, done} !== {e_cnt, e_busy, e_done}) begin
        n_bad++;
        $display("FAIL basic_c%0d: count/busy/done got %0d/%b/%b want %0d/%b/%b",
                 c, count, busy, done, e_cnt, e_busy, e_done);
      end
      tick();
    end
    // hold is ignored in IDLE: count must stay 0 and no run starts
    hold = 1'b1;
    tick();
    hold = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL idle_hold: count/busy/done got %0d/%b/%b want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_zero_load();
    start    = 1'b1;
    load_val = 4'd0;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({count, busy, done, zero} !== {4'd0, 3'b011}) begin
      n_bad++;
      $display("FAIL zero_load_done: count/busy/done/zero got %0d/%b/%b/%b want 0/0/1/1",
               count, busy, done, zero);
    end
    tick();
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL zero_load_idle: count/busy/done got %0d/%b/%b want 0/0/0", count, busy, done);
    end
  endtask

  // load_val=15 with hold over three edges: 13 persists, done at cycle 19
  task automatic test_hold();
    logic [3:0] e_cnt;
    start    = 1'b1;
    load_val = 4'd15;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 3)       e_cnt = 4'(16 - c);
      else if (c <= 6)  e_cnt = 4'd13;
      else if (c <= 19) e_cnt = 4'(19 - c);
      else              e_cnt = 4'd0;
      n_cmp++;
      if ({count, busy, done} !== {e_cnt, (c <= 18), (c == 19)}) begin
        n_bad++;
        $display("FAIL hold_c%0d: count/busy/done got %0d/%b/%b want %0d/%b/%b",
                 c, count, busy, done, e_cnt, (c <= 18), (c == 19));
      end
      if (c == 3) hold = 1'b1;
      if (c == 6) hold = 1'b0;
      tick();
    end
  endtask

  // A second start with load_val=9 during a run of 3 must be ignored
  task automatic test_back_to_back();
    logic [3:0] e_cnt;
    start    = 1'b1;
    load_val = 4'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e_cnt = (c <= 4) ? 4'(4 - c) : 4'd0;
      n_cmp++;
      if ({count, busy, done} !== {e_cnt, (c <= 3), (c == 4)}) begin
        n_bad++;
        $display("FAIL restart_c%0d: count/busy/done got %0d/%b/%b want %0d/%b/%b",
                 c, count, busy, done, e_cnt, (c <= 3), (c == 4));
      end
      if (c == 2) begin
        start    = 1'b1;
        load_val = 4'd9;
      end
      if (c == 3) start = 1'b0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    start    = 1'b1;
    load_val = 4'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (count !== 4'd2) begin
      n_bad++;
      $display("FAIL areset_pre: count got %0d want 2", count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, busy, done, zero} !== {4'd0, 3'b001}) begin
      n_bad++;
      $display("FAIL areset_immediate: count/busy/done/zero got %0d/%b/%b/%b want 0/0/0/1",
               count, busy, done, zero);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({count, busy, done} !== {4'd0, 2'b00}) begin
        n_bad++;
        $display("FAIL areset_no_done_%0d: count/busy/done got %0d/%b/%b want 0/0/0",
                 c, count, busy, done);
      end
    end
    // First start after release behaves normally
    start    = 1'b1;
    load_val = 4'd1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {4'd1, 2'b10}) begin
      n_bad++;
      $display("FAIL areset_restart_run: count/busy/done got %0d/%b/%b want 1/1/0", count, busy, done);
    end
    tick();
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b01}) begin
      n_bad++;
      $display("FAIL areset_restart_done: count/busy/done got %0d/%b/%b want 0/0/1", count, busy, done);
    end
    tick();
  endtask

  task automatic test_dec_exhaustive();
    logic [3:0] e_s;
    for (int i = 0; i < 16; i++) begin
      t_a = 4'(i);
      e_s = 4'((i + 15) % 16);
      #1;
      n_cmp++;
      if ({t_s, t_b} !== {e_s, (i == 0)}) begin
        n_bad++;
        $display("FAIL dec_a%0d: s/bOut got %0d/%b want %0d/%b", i, t_s, t_b, e_s, (i == 0));
      end
    end
  endtask

`ifdef ITER_CNT_ABORT_EN
  task automatic test_abort();
    // Abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL abort_idle: count/busy/done got %0d/%b/%b want 0/0/0", count, busy, done);
    end
    start    = 1'b1;
    load_val = 4'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (count !== 4'd6) begin
      n_bad++;
      $display("FAIL abort_pre: count got %0d want 6", count);
    end
    abort = 1'b1;
    hold  = 1'b1;
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL abort_idle_next: count/busy/done got %0d/%b/%b want 0/0/0", count, busy, done);
    end
    tick();
    n_cmp++;
    if ({count, busy, done} !== {4'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL abort_no_done: count/busy/done got %0d/%b/%b want 0/0/0", count, busy, done);
    end
  endtask
`endif

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    start    = 1'b0;
    load_val = 4'd0;
    hold     = 1'b0;
    t_a      = 4'd0;
`ifdef ITER_CNT_ABORT_EN
    abort    = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero_load();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_dec_exhaustive();
`ifdef ITER_CNT_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_iter_down_counter
`default_nettype wire
